// File: rtl/mult_share_arbiter_pkg.sv
// Shared state encoding, default sizes and index-width helper for mult_share_arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 4;
    localparam int DEF_TIMEOUT = 31;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_pick import mult_arb_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        logic [IW-1:0] c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int i = 0; i < NREQ; i++) begin
            c = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[c]) begin
                any    = 1'b1;
                idx    = c;
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one sequential multiplier among NREQ clients.
// Define MULT_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT cycles and report expiry on resp_err.
module mult_share_arbiter import mult_arb_pkg::*; #(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [2*W-1:0]          resp_prod,
    output logic                    resp_err,
    output logic [W-1:0]            mul_a,
    output logic [W-1:0]            mul_b,
    output logic                    mul_in_valid,
    input  logic [2*W-1:0]          mul_prod,
    input  logic                    mul_done
);

    localparam int IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mult_share_arbiter: unsupported NREQ/TIMEOUT");
    end

    arb_state_t      r_state, w_next;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx, r_ptr, r_g, r_id;
    logic            w_any, w_take, w_done;
    logic [W-1:0]    r_a, r_b;
    logic [2*W-1:0]  r_prod;
    logic [W-1:0]    w_opa [NREQ];
    logic [W-1:0]    w_opb [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_opa[i] = req_a[i*W +: W];
        assign w_opb[i] = req_b[i*W +: W];
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err, w_expire;
    assign w_expire = (r_cnt == CW'(TIMEOUT));
`endif

    always_comb begin
        w_next       = r_state;
        w_take       = 1'b0;
        w_done       = 1'b0;
        req_ready    = '0;
        mul_in_valid = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // ready is suppressed while reset is held so a reset cycle never looks like an accept
                if (!reset) req_ready = w_gnt;
                if (w_any) begin
                    w_next = ST_ISSUE;
                    w_take = 1'b1;
                end
            end
            ST_ISSUE: begin
                mul_in_valid = 1'b1;
                w_next       = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    w_next = ST_RESP;
                    w_done = 1'b1;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_next = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_g    <= '0;
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else begin
            if (w_take) begin
                r_g <= w_idx;
                r_a <= w_opa[w_idx];
                r_b <= w_opb[w_idx];
            end
            if (w_done) begin
                r_prod <= mul_prod;
                r_id   <= r_g;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            if (r_state == ST_WAIT && !mul_done && w_expire) begin
                r_prod <= '0;
                r_id   <= r_g;
            end
`endif
            if (r_state == ST_RESP) r_ptr <= (r_g == IW'(NREQ - 1)) ? '0 : r_g + 1'b1;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)                r_cnt <= '0;
            else if (r_state == ST_WAIT && !w_expire) r_cnt <= r_cnt + 1'b1;
            if (w_done)                              r_err <= 1'b0;
            else if (r_state == ST_WAIT && w_expire) r_err <= 1'b1;
        end
    end
    assign resp_err = r_err && (r_state == ST_RESP);
`else
    assign resp_err = 1'b0;
`endif

    assign resp_id   = r_id;
    assign resp_prod = r_prod;
    assign mul_a     = r_a;
    assign mul_b     = r_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier on the core side, expected-result queue on the client side.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    typedef struct {
        int id;
        int prod;
        int err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [2*W-1:0]    resp_prod;
    logic              resp_err;
    logic [W-1:0]      mul_a, mul_b;
    logic              mul_in_valid;
    logic [2*W-1:0]    mul_prod = '0;
    logic              mul_done = 1'b0;

    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];

    int         m_lat   = 3;
    bit         m_en    = 1'b1;
    bit         m_force = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_cnt   = 0;
    logic [W-1:0] m_a = '0, m_b = '0;

    always #5 clk = ~clk;

    mult_share_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_prod    (resp_prod),
        .resp_err     (resp_err),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_in_valid (mul_in_valid),
        .mul_prod     (mul_prod),
        .mul_done     (mul_done)
    );

    // Multiplier model: done m_lat cycles after the start pulse; m_force adds a bogus done in the start cycle.
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy   = 1'b0;
                mul_done = m_en;
                mul_prod = {4'b0, m_a} * {4'b0, m_b};
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        if (mul_in_valid) begin
            m_busy = 1'b1;
            m_cnt  = m_lat - 1;
            m_a    = mul_a;
            m_b    = mul_b;
            if (m_force) begin
                mul_done = 1'b1;
                mul_prod = 8'hAA;
            end
        end
    end

    task automatic drive_req(input int i, input int a, input int b);
        req_valid[i]    = 1'b1;
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; req_a = '1; req_b = '1;
        repeat (2) @(negedge clk);
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        nvec++; if (resp_id !== 2'd0 || resp_prod !== 8'd0 || resp_err !== 1'b0) begin
            nerr++; $display("FAIL reset_resp got id=%0d prod=%0d err=%b want 0/0/0", resp_id, resp_prod, resp_err); end
        nvec++; if (mul_a !== 4'd0 || mul_b !== 4'd0 || mul_in_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_mul got a=%0d b=%0d v=%b want 0/0/0", mul_a, mul_b, mul_in_valid); end
        reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(negedge clk);
        nvec++; if (resp_valid !== 1'b0 || mul_in_valid !== 1'b0 || req_ready !== 4'b0000) begin
            nerr++; $display("FAIL reset_idle got rv=%b miv=%b rdy=%b want 0/0/0000", resp_valid, mul_in_valid, req_ready); end
    endtask

    task automatic test_single();
        exp_t e;
        int   nresp = 0;
        m_lat = 3; m_en = 1'b1; m_force = 1'b0;
        @(negedge clk);
        drive_req(0, 3, 5);
        sb.push_back('{0, 15, 0});
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (t == 0) begin
                nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL single_ready got %b want 0001", req_ready); end
            end
            if (t == 1) begin
                nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL single_ready_busy got %b want 0000", req_ready); end
                nvec++; if (mul_in_valid !== 1'b1 || mul_a !== 4'd3 || mul_b !== 4'd5) begin
                    nerr++; $display("FAIL single_issue got v=%b a=%0d b=%0d want 1/3/5", mul_in_valid, mul_a, mul_b); end
                req_valid = '0;
            end
            if (t == 2) begin
                nvec++; if (mul_in_valid !== 1'b0) begin nerr++; $display("FAIL single_issue_len got %b want 0", mul_in_valid); end
            end
            if (resp_valid) begin
                nresp++;
                nvec++; if (t != 2 + m_lat) begin nerr++; $display("FAIL single_resp_cycle got %0d want %0d", t, 2 + m_lat); end
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL single_extra_resp got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod) || resp_err !== 1'(e.err)) begin
                        nerr++; $display("FAIL single_resp got id=%0d prod=%0d err=%b want id=%0d prod=%0d err=%0d",
                                         resp_id, resp_prod, resp_err, e.id, e.prod, e.err); end
                end
            end
        end
        nvec++; if (nresp != 1 || sb.size() != 0) begin nerr++; $display("FAIL single_count got %0d want 1", nresp); end
    endtask

    task automatic test_round_robin();
        int   gexp[5] = '{0, 1, 2, 3, 0};
        int   gi = 0, nresp = 0, last_g = 0;
        exp_t e;
        m_lat = 2; m_en = 1'b1; m_force = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < NREQ; i++) drive_req(i, i + 1, 15);
        for (int k = 0; k < 5; k++) sb.push_back('{gexp[k], (gexp[k] + 1) * 15, 0});
        for (int t = 0; t < 80 && nresp < 5; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (req_ready !== 4'b0000) begin
                nvec++;
                if (gi >= 5) begin nerr++; $display("FAIL rr_extra_grant got %b want none", req_ready); end
                else if (req_ready !== NREQ'(1 << gexp[gi])) begin
                    nerr++; $display("FAIL rr_grant got %b want req%0d", req_ready, gexp[gi]); end
                if (gi > 0) begin
                    nvec++; if (t - last_g != m_lat + 3) begin
                        nerr++; $display("FAIL rr_spacing got %0d want %0d", t - last_g, m_lat + 3); end
                end
                last_g = t;
                gi++;
            end
            if (resp_valid) begin
                nresp++;
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL rr_extra_resp got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod) || resp_err !== 1'(e.err)) begin
                        nerr++; $display("FAIL rr_resp got id=%0d prod=%0d err=%b want id=%0d prod=%0d err=%0d",
                                         resp_id, resp_prod, resp_err, e.id, e.prod, e.err); end
                end
                if (nresp == 5) req_valid = '0;
            end
        end
        nvec++; if (gi != 5 || nresp != 5) begin nerr++; $display("FAIL rr_count got grants=%0d resps=%0d want 5/5", gi, nresp); end
    endtask

    task automatic test_max_operands();
        exp_t e;
        int   nresp = 0;
        m_lat = 4;
        @(negedge clk);
        drive_req(2, 15, 15);
        sb.push_back('{2, 225, 0});
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (t == 0) begin
                nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL max_ready got %b want 0100", req_ready); end
            end
            if (t == 1) begin
                nvec++; if (mul_a !== 4'd15 || mul_b !== 4'd15) begin
                    nerr++; $display("FAIL max_issue got a=%0d b=%0d want 15/15", mul_a, mul_b); end
                req_valid = '0;
            end
            if (resp_valid) begin
                nresp++;
                nvec++; if (t != 2 + m_lat) begin nerr++; $display("FAIL max_resp_cycle got %0d want %0d", t, 2 + m_lat); end
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL max_extra_resp got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod)) begin
                        nerr++; $display("FAIL max_resp got id=%0d prod=%0d want id=%0d prod=%0d", resp_id, resp_prod, e.id, e.prod); end
                end
            end
        end
        nvec++; if (nresp != 1) begin nerr++; $display("FAIL max_count got %0d want 1", nresp); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   stray = 0, nresp = 0;
        m_lat = 5;
        @(negedge clk);
        drive_req(1, 7, 9);
        for (int t = 0; t < 13; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (t == 1) req_valid = '0;
            if (t == 3) reset = 1'b1;
            if (t == 4) begin
                nvec++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || mul_in_valid !== 1'b0) begin
                    nerr++; $display("FAIL rstmid_ctl got rdy=%b rv=%b miv=%b want 0", req_ready, resp_valid, mul_in_valid); end
                nvec++; if (resp_id !== 2'd0 || resp_prod !== 8'd0 || resp_err !== 1'b0) begin
                    nerr++; $display("FAIL rstmid_resp got id=%0d prod=%0d err=%b want 0", resp_id, resp_prod, resp_err); end
                nvec++; if (mul_a !== 4'd0 || mul_b !== 4'd0) begin
                    nerr++; $display("FAIL rstmid_mul got a=%0d b=%0d want 0/0", mul_a, mul_b); end
                reset = 1'b0;
            end
            if (t > 4 && (resp_valid !== 1'b0 || req_ready !== 4'b0000)) stray++;
        end
        nvec++; if (stray != 0) begin nerr++; $display("FAIL rstmid_stale_done got %0d stray cycles want 0", stray); end
        nvec++; if (resp_prod !== 8'd0) begin nerr++; $display("FAIL rstmid_prod_hold got %0d want 0", resp_prod); end
        m_lat = 2;
        drive_req(1, 4, 6);
        drive_req(3, 1, 1);
        sb.push_back('{1, 24, 0});
        #1;
        nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL rstmid_next_grant got %b want 0010", req_ready); end
        for (int t = 1; t < 15; t++) begin
            @(negedge clk);
            #1;
            if (t == 1) req_valid = '0;
            if (resp_valid) begin
                nresp++;
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL rstmid_extra_resp got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod) || t != 2 + m_lat) begin
                        nerr++; $display("FAIL rstmid_resp2 got id=%0d prod=%0d t=%0d want id=%0d prod=%0d t=%0d",
                                         resp_id, resp_prod, t, e.id, e.prod, 2 + m_lat); end
                end
            end
        end
        nvec++; if (nresp != 1) begin nerr++; $display("FAIL rstmid_count got %0d want 1", nresp); end
    endtask

    task automatic test_spurious_done();
        exp_t e;
        int   nresp = 0;
        m_lat = 3; m_force = 1'b1;
        @(negedge clk);
        drive_req(0, 6, 7);
        sb.push_back('{0, 42, 0});
        for (int t = 0; t < 15; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (t == 1) req_valid = '0;
            if (t == 2) m_force = 1'b0;
            if (resp_valid) begin
                nresp++;
                nvec++; if (t != 2 + m_lat) begin nerr++; $display("FAIL spur_resp_cycle got %0d want %0d", t, 2 + m_lat); end
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL spur_extra_resp got prod=%0d want none", resp_prod); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod)) begin
                        nerr++; $display("FAIL spur_resp got id=%0d prod=%0d want id=%0d prod=%0d", resp_id, resp_prod, e.id, e.prod); end
                end
            end
        end
        nvec++; if (nresp != 1) begin nerr++; $display("FAIL spur_count got %0d want 1", nresp); end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 31;

    task automatic test_timeout();
        exp_t e;
        int   nresp = 0;
        m_lat = 2; m_en = 1'b0;
        @(negedge clk);
        drive_req(3, 2, 3);
        sb.push_back('{3, 0, 1});
        for (int t = 0; t < 45; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (t == 1) req_valid = '0;
            if (resp_valid) begin
                nresp++;
                nvec++; if (t != 2 + TIMEOUT + 1) begin nerr++; $display("FAIL tmo_resp_cycle got %0d want %0d", t, 2 + TIMEOUT + 1); end
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL tmo_extra_resp got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_id !== 2'(e.id) || resp_prod !== 8'(e.prod) || resp_err !== 1'(e.err)) begin
                        nerr++; $display("FAIL tmo_resp got id=%0d prod=%0d err=%b want id=%0d prod=%0d err=%0d",
                                         resp_id, resp_prod, resp_err, e.id, e.prod, e.err); end
                end
            end
        end
        nvec++; if (nresp != 1) begin nerr++; $display("FAIL tmo_count got %0d want 1", nresp); end
        m_en = 1'b1; nresp = 0;
        drive_req(3, 2, 3);
        sb.push_back('{3, 6, 0});
        #1;
        nvec++; if (req_ready !== 4'b1000) begin nerr++; $display("FAIL tmo_idle_again got %b want 1000", req_ready); end
        for (int t = 1; t < 15; t++) begin
            @(negedge clk);
            #1;
            if (t == 1) req_valid = '0;
            if (resp_valid) begin
                nresp++;
                if (sb.size() == 0) begin nvec++; nerr++; $display("FAIL tmo_extra_resp2 got id=%0d want none", resp_id); end
                else begin
                    e = sb.pop_front();
                    nvec++; if (resp_prod !== 8'(e.prod) || resp_err !== 1'(e.err)) begin
                        nerr++; $display("FAIL tmo_resp2 got prod=%0d err=%b want prod=%0d err=%0d", resp_prod, resp_err, e.prod, e.err); end
                end
            end
        end
        nvec++; if (nresp != 1) begin nerr++; $display("FAIL tmo_count2 got %0d want 1", nresp); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_operands();
        test_reset_mid();
        test_spurious_done();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
